bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer_pkg.sv | 12 +
 rtl/ser_hold_reg.sv | 35 +++
 rtl/bit_serializer.sv | 153 +++++++++++++++
 tb/tb_bit_serializer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the bit serializer.
// Emission order is selected by BIT_SERIALIZER_LSB_FIRST_EN (MSB-first when undefined).
package bit_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int WS_W = 16;

endpackage

// File: rtl/ser_hold_reg.sv
// Single-entry pending register for the serializer, holding a word and its normalized length.
// Never written and read in the same cycle: the writer only writes while full is low.
module ser_hold_reg #(
    parameter int W  = 8,
    parameter int LW = $clog2(W) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic [LW-1:0] wr_len,
    input  logic          rd_en,
    output logic          full,
    output logic [W-1:0]  data,
    output logic [LW-1:0] len
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            data <= '0;
            len  <= '0;
        end else begin
            if (rd_en) begin
                full <= 1'b0;
            end
            if (wr_en) begin
                full <= 1'b1;
                data <= wr_data;
                len  <= wr_len;
            end
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// Word-to-bit serializer feeding a downstream DFA, with one word of look-ahead buffering.
// BIT_SERIALIZER_LSB_FIRST_EN selects LSB-first emission; the default is MSB-first.
//
// state | meaning
// IDLE  | no active word, bit_valid low
// SHIFT | emitting bits of the active word, bit_valid high
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int W  = 8,
    parameter int LW = $clog2(W) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_valid,
    input  logic [W-1:0]    load_data,
    input  logic [LW-1:0]   load_len,
    output logic            load_ready,
    input  logic            hold,
    output logic            bit_out,
    output logic            bit_valid,
    output logic            first,
    output logic            last,
    output logic [WS_W-1:0] words_sent
);

    state_t          state_q, state_d;
    logic [W-1:0]    sreg_q;
    logic [LW-1:0]   len_q;
    logic [LW-1:0]   idx_q;
    logic [WS_W-1:0] ws_q;

    logic            pend_full;
    logic [W-1:0]    pend_data;
    logic [LW-1:0]   pend_len;

    logic [LW-1:0]   in_len;
    logic            accept;
    logic            is_last;
    logic            advance;
    logic            retire;
    logic            ld_from_in;
    logic            ld_from_pend;
    logic            pend_wr;

    // Place the word so the first bit to emit sits at the shifter's output end.
    function automatic logic [W-1:0] align(input logic [W-1:0] d, input logic [LW-1:0] n);
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
        align = d;
`else
        align = d << (W - int'(n));
`endif
    endfunction

    assign in_len     = (load_len == '0 || load_len > LW'(W)) ? LW'(W) : load_len;
    assign load_ready = ~pend_full;
    assign accept     = load_valid & load_ready;
    assign is_last    = (state_q == SHIFT) && (idx_q == len_q - LW'(1));
    assign advance    = (state_q == SHIFT) && !hold;
    assign retire     = advance && is_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ld_from_in   = 1'b0;
        ld_from_pend = 1'b0;
        pend_wr      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ld_from_in = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (retire) begin
                    if (pend_full) begin
                        ld_from_pend = 1'b1;
                    end else if (accept) begin
                        ld_from_in = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (accept) begin
                    pend_wr = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
            len_q  <= '0;
            idx_q  <= '0;
            ws_q   <= '0;
        end else begin
            if (ld_from_pend) begin
                sreg_q <= align(pend_data, pend_len);
                len_q  <= pend_len;
                idx_q  <= '0;
            end else if (ld_from_in) begin
                sreg_q <= align(load_data, in_len);
                len_q  <= in_len;
                idx_q  <= '0;
            end else if (advance) begin
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
                sreg_q <= sreg_q >> 1;
`else
                sreg_q <= sreg_q << 1;
`endif
                idx_q  <= idx_q + LW'(1);
            end
            if (retire) begin
                ws_q <= ws_q + WS_W'(1);
            end
        end
    end

    ser_hold_reg #(
        .W  (W),
        .LW (LW)
    ) u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (pend_wr),
        .wr_data (load_data),
        .wr_len  (in_len),
        .rd_en   (ld_from_pend),
        .full    (pend_full),
        .data    (pend_data),
        .len     (pend_len)
    );

    assign bit_valid  = (state_q == SHIFT);
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
    assign bit_out    = bit_valid & sreg_q[0];
`else
    assign bit_out    = bit_valid & sreg_q[W-1];
`endif
    assign first      = bit_valid && (idx_q == '0);
    assign last       = is_last;
    assign words_sent = ws_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: accepted words expand into expected bit records,
// and a negedge monitor compares every presented bit against the queue head.
module tb_bit_serializer;

    localparam int W  = 8;
    localparam int LW = $clog2(W) + 1;

    typedef struct {
        logic b;
        logic f;
        logic l;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_valid = 1'b0;
    logic [W-1:0]  load_data = '0;
    logic [LW-1:0] load_len = '0;
    logic          hold = 1'b0;
    logic          load_ready;
    logic          bit_out;
    logic          bit_valid;
    logic          first;
    logic          last;
    logic [15:0]   words_sent;

    exp_t        q[$];
    logic [15:0] ws_model = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    bit_serializer #(.W(W), .LW(LW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_len   (load_len),
        .load_ready (load_ready),
        .hold       (hold),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .first      (first),
        .last       (last),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Reference: a word of n bits becomes n records, ordered by emission rule.
    task automatic push_word(input logic [W-1:0] d, input int len);
        int   n;
        int   pos;
        exp_t e;
        n = (len == 0 || len > W) ? W : len;
        for (int i = 0; i < n; i++) begin
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
            pos = i;
`else
            pos = n - 1 - i;
`endif
            e.b = d[pos];
            e.f = (i == 0);
            e.l = (i == n - 1);
            q.push_back(e);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n && load_valid && load_ready)
            push_word(load_data, int'(load_len));
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("words_sent", 32'(words_sent), 32'(ws_model));
            if (q.size() == 0) begin
                chk("idle_valid", 32'(bit_valid), 32'd0);
            end else begin
                chk("bit_valid", 32'(bit_valid), 32'd1);
                chk("bit_out", 32'(bit_out), 32'(q[0].b));
                chk("first", 32'(first), 32'(q[0].f));
                chk("last", 32'(last), 32'(q[0].l));
                if (!hold) begin
                    if (q[0].l) ws_model = ws_model + 16'd1;
                    void'(q.pop_front());
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [W-1:0] d, input logic [LW-1:0] l);
        int budget = 200;
        load_data  = d;
        load_len   = l;
        load_valid = 1'b1;
        while (!load_ready && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (!load_ready) timeout_fail("send");
        @(posedge clk); #1;
        load_valid = 1'b0;
    endtask

    task automatic drain();
        int budget = 500;
        while ((q.size() != 0 || bit_valid) && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (budget == 0) timeout_fail("drain");
    endtask

    initial begin
        logic [15:0] base;

        #1;
        chk("rst_bit_valid", 32'(bit_valid), 32'd0);
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        chk("rst_words_sent", 32'(words_sent), 32'd0);
        chk("rst_first_last", {30'd0, first, last}, 32'd0);
        chk("rst_bit_out", 32'(bit_out), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Four-bit word, MSB-first gives 1,1,0,0
        base = words_sent;
        send(8'b0000_1100, 4'd4);
        drain();
        chk("single_word_count", 32'(words_sent), 32'(base + 16'd1));

        // Back-to-back words: second lands in pending, stream stays contiguous
        base = words_sent;
        send(8'b0000_1011, 4'd4);
        send(8'b0000_0100, 4'd3);
        chk("pend_full_ready", 32'(load_ready), 32'd0);
        drain();
        chk("b2b_count", 32'(words_sent), 32'(base + 16'd2));

        // Stall during the second bit
        send(8'b0000_1101, 4'd4);
        @(posedge clk); #1;
        hold = 1'b1;
        repeat (3) @(posedge clk);
        #1 hold = 1'b0;
        drain();

        // Length 0 means full width; length 1 gives first and last together
        send(8'hA5, 4'd0);
        send(8'h01, 4'd1);
        drain();
        send(8'h3C, 4'd12);
        drain();
        send(8'b0000_0011, 4'd4);
        drain();

        // Reset mid-word with the pending register occupied
        send(8'hFF, 4'd8);
        send(8'h55, 4'd8);
        chk("pre_reset_ready", 32'(load_ready), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_bit_valid", 32'(bit_valid), 32'd0);
        chk("async_load_ready", 32'(load_ready), 32'd1);
        chk("async_words_sent", 32'(words_sent), 32'd0);
        chk("async_first_last", {30'd0, first, last}, 32'd0);
        q.delete();
        ws_model = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle", 32'(bit_valid), 32'd0);

        // Randomized traffic with stalls and out-of-range lengths
        for (int i = 0; i < 3000; i++) begin
            load_valid = ($urandom_range(0, 2) != 0);
            load_data  = W'($urandom);
            load_len   = LW'($urandom_range(0, (1 << LW) - 1));
            hold       = ($urandom_range(0, 4) == 0);
            @(posedge clk); #1;
        end
        load_valid = 1'b0;
        hold = 1'b0;
        drain();
        chk("final_count", 32'(words_sent), 32'(ws_model));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
